pipe_ctrl: RTL
==============

# pipe_ctrl

Parametrised pipeline control unit for the in-order integer core. It tracks one valid bit per pipeline stage and turns per-stage stall requests, a multi-cycle execute request and a front-end flush into per-stage hold (`stall`) and NOP-insert (`bubble`) controls. Every pipeline register (pc_reg, if_id, id_ex, ex_mem, mem_wb and any added stages) consumes these controls. It also keeps a saturating count of front-end stall cycles for performance debug.

## Interface
Parameters:
- STAGES, 5: number of pipeline stages, legal range 2..8. Stage 0 is fetch and stage STAGES-1 is writeback.
- EX_STAGE, 2: index of the execute stage, where multi-cycle operations run. Range 0..STAGES-1.
- FLUSH_DEPTH, 2: stages 0..FLUSH_DEPTH-1 are killed by `flush`. Range 1..STAGES.
- CNT_W, 4: width of `mc_cycles`.
- STAT_W, 16: width of `stall_cycles`.

Ports (`clk`/`rst` are one clock with asynchronous active-low reset):
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  fetch holds a valid instruction this cycle.
- stallreq  in  STAGES  bit i set: stage i cannot complete this cycle.
- mc_start  in  1  multi-cycle operation request from the execute stage.
- mc_cycles  in  CNT_W  number of extra cycles the operation needs; 0 means no stall.
- flush  in  1  kill stages 0..FLUSH_DEPTH-1 (taken branch or redirect).
- stat_clr  in  1  synchronous clear of `stall_cycles`.
- stall  out  STAGES  bit i set: the register at the output of stage i holds its contents.
- bubble  out  STAGES  bit i set: the register at the output of stage i loads a NOP/invalid entry.
- valid  out  STAGES  registered per-stage valid bits.
- mc_busy  out  1  FSM is in BUSY.
- mc_done  out  1  pulse in the last stall cycle of a multi-cycle operation.
- retire  out  1  equals valid[STAGES-1].
- stall_cycles  out  STAT_W  saturating count of cycles with stall[0]=1.

## Operation
- Stall request: mc_req = (IDLE & mc_start & valid[EX_STAGE] & mc_cycles≠0) | BUSY.
- Effective request vector: r = stallreq, with r[EX_STAGE] OR'd with mc_req.
- Stall rule: h = highest set index in r. Then stall[j]=1 for j≤h, and stall[j]=0 for j>h. With no request, stall=0.
- Bubble rule: bubble[0]=0. For i≥1, bubble[i]=stall[i-1] & ~stall[i]. This gives exactly one bubble, at h+1, when h<STAGES-1.
- Valid update, without flush:
  - valid[0] ← stall[0] ? valid[0] : in_valid.
  - valid[i] ← stall[i] ? valid[i] : (stall[i-1] ? 0 : valid[i-1]).
- Flush has priority for stages i<FLUSH_DEPTH:
  - valid[i] ← 0.
  - stall[i] is forced to 0 and bubble[i] to 1.
  - Stages ≥FLUSH_DEPTH follow the normal rules. bubble[FLUSH_DEPTH] is computed from the forced stall value.
  - If EX_STAGE<FLUSH_DEPTH, flush also aborts the FSM: next state IDLE, cnt←0, and no mc_done.
- Multi-cycle FSM, with N=mc_cycles:
  - IDLE: when mc_req is raised by mc_start:
    - N=1: stall that cycle only, mc_done=1, remain IDLE.
    - N≥2: cnt←N-1 and go to BUSY.
  - BUSY: mc_start is ignored; cnt←cnt-1. When cnt=1, mc_done=1 and go to IDLE.
  - Net effect: exactly N stall cycles starting in the mc_start cycle. The instruction occupies EX for N+1 cycles.
  - mc_start with valid[EX_STAGE]=0 is ignored.
- Statistics: stall_cycles increments when stall[0]=1 and holds at 2^STAT_W-1. stat_clr wins over increment.

## Timing
- Reset (rst=0, asynchronous) sets valid=0, IDLE, cnt=0, stall_cycles=0.
- While in reset, stall, bubble, mc_busy, mc_done and retire are forced to 0.
- stall, bubble and mc_done are combinational from the current inputs and state; there is no added latency. valid, mc_busy and stall_cycles are registered.
- An instruction entering with in_valid in cycle t gives retire at cycle t+STAGES with no stalls.
- Reset asserted mid-operation abandons the FSM immediately. Pipeline contents are invalid after reset release.
- Simultaneous stallreq[j] and mc_req: the higher index decides h. The FSM counter keeps running regardless of other stalls.

## Test plan
All scenarios use STAGES=5, EX_STAGE=2, FLUSH_DEPTH=2.
- Streaming: reset, then in_valid=1 for 6 cycles with no stalls → valid fills 00001→11111, retire first at cycle 5, stall=bubble=0 throughout.
- Stall request: stallreq=00100 for one cycle with a full pipe → stall=00111, bubble=01000; next cycle valid[3]=0 and the others are held.
- Multi-cycle: mc_start with mc_cycles=3 and valid[2]=1 → stall=00111 for 3 cycles, mc_busy high 2 cycles, mc_done only in the 3rd cycle; mc_cycles=0 → no stall.
- Flush during a stall: flush together with stallreq=00010 → stall=00000, bubble=00011, valid[1:0]=0 next cycle; stage 2 advances normally.
- Async reset during BUSY: rst low mid-count → mc_busy=0 and valid=0 immediately, without a clock edge; after release a fresh mc_start works.
- Saturation: STAT_W=2, hold stallreq[0] for 6 cycles → stall_cycles 1,2,3,3,3,3; stat_clr → 0.

Source files
------------

// File: rtl/pipe_ctrl_if.sv
// Pipeline control bundle: the core drives requests and consumes the
// per-stage hold/NOP controls, valid bits and debug statistics.
interface pipe_ctrl_if #(
  parameter int STAGES = 5,
  parameter int CNT_W  = 4,
  parameter int STAT_W = 16
);
  logic              in_valid;
  logic [STAGES-1:0] stallreq;
  logic              mc_start;
  logic [CNT_W-1:0]  mc_cycles;
  logic              flush;
  logic              stat_clr;
  logic [STAGES-1:0] stall;
  logic [STAGES-1:0] bubble;
  logic [STAGES-1:0] valid;
  logic              mc_busy;
  logic              mc_done;
  logic              retire;
  logic [STAT_W-1:0] stall_cycles;

  // Core side: raises requests, observes controls.
  modport master (
    output in_valid, stallreq, mc_start, mc_cycles, flush, stat_clr,
    input  stall, bubble, valid, mc_busy, mc_done, retire, stall_cycles
  );

  // Control unit side.
  modport slave (
    input  in_valid, stallreq, mc_start, mc_cycles, flush, stat_clr,
    output stall, bubble, valid, mc_busy, mc_done, retire, stall_cycles
  );
endinterface

// File: rtl/pipe_ctrl.sv
// In-order pipeline control unit: per-stage valid tracking, stall/bubble
// generation from stall requests, a multi-cycle execute FSM and a
// front-end flush, plus a saturating front-end stall-cycle counter.
module pipe_ctrl #(
  parameter int STAGES      = 5,
  parameter int EX_STAGE    = 2,
  parameter int FLUSH_DEPTH = 2,
  parameter int CNT_W       = 4,
  parameter int STAT_W      = 16
) (
  input logic       clk,
  input logic       rst,
  pipe_ctrl_if.slave bus
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Flushing kills the execute stage too, so a running operation must die.
  localparam bit EX_FLUSHED = (EX_STAGE < FLUSH_DEPTH);

  state_t            state;
  state_t            state_nx;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nx;
  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] valid_nx;
  logic [STAGES-1:0] req_vec;
  logic [STAGES-1:0] stall_int;
  logic [STAGES-1:0] bubble_int;
  logic              acc;
  logic              mc_take;
  logic              mc_req;
  logic              mc_done_int;
  logic              flush_abort;
  logic [STAT_W-1:0] stat_q;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + STAT_W'(1);
  endfunction

  // A new operation is accepted only from IDLE with a live instruction in EX
  // and a nonzero cycle count; BUSY keeps requesting until the count expires.
  assign mc_take     = (state == IDLE) && bus.mc_start && valid_q[EX_STAGE] &&
                       (bus.mc_cycles != '0);
  assign mc_req      = mc_take || (state == BUSY);
  assign flush_abort = EX_FLUSHED && bus.flush;

  // Stall everything at or below the highest requesting stage; flushed stages
  // never hold, they take a bubble instead.
  always_comb begin
    req_vec           = bus.stallreq;
    req_vec[EX_STAGE] = req_vec[EX_STAGE] | mc_req;
    acc               = 1'b0;
    stall_int         = '0;
    for (int j = STAGES - 1; j >= 0; j--) begin
      acc          = acc | req_vec[j];
      stall_int[j] = acc & ~(bus.flush && (j < FLUSH_DEPTH));
    end
    bubble_int    = '0;
    bubble_int[0] = bus.flush;
    for (int i = 1; i < STAGES; i++) begin
      bubble_int[i] = (bus.flush && (i < FLUSH_DEPTH)) |
                      (stall_int[i-1] & ~stall_int[i]);
    end
  end

  // Next valid bits: held stages keep theirs, the stage just above a stall
  // boundary receives a NOP, flushed stages are cleared.
  always_comb begin
    valid_nx    = '0;
    valid_nx[0] = stall_int[0] ? valid_q[0] : bus.in_valid;
    for (int i = 1; i < STAGES; i++) begin
      valid_nx[i] = stall_int[i] ? valid_q[i] :
                    (stall_int[i-1] ? 1'b0 : valid_q[i-1]);
    end
    for (int i = 0; i < STAGES; i++) begin
      if (bus.flush && (i < FLUSH_DEPTH)) valid_nx[i] = 1'b0;
    end
  end

  // Multi-cycle FSM: N stall cycles total, the first one spent in IDLE.
  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    mc_done_int = 1'b0;
    case (state)
      IDLE: begin
        if (mc_take) begin
          if (bus.mc_cycles == CNT_W'(1)) begin
            mc_done_int = 1'b1;
          end else begin
            cnt_nx   = bus.mc_cycles - CNT_W'(1);
            state_nx = BUSY;
          end
        end
      end
      BUSY: begin
        cnt_nx = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          mc_done_int = 1'b1;
          state_nx    = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
    if (flush_abort) begin
      state_nx    = IDLE;
      cnt_nx      = '0;
      mc_done_int = 1'b0;
    end
  end

  // FSM state and remaining-cycle counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Per-stage valid bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) valid_q <= '0;
    else      valid_q <= valid_nx;
  end

  // Saturating count of front-end stall cycles; clear beats increment.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)              stat_q <= '0;
    else if (bus.stat_clr) stat_q <= '0;
    else if (stall_int[0]) stat_q <= sat_inc(stat_q);
  end

  // Combinational controls are silenced while reset is held.
  assign bus.stall        = rst ? stall_int  : '0;
  assign bus.bubble       = rst ? bubble_int : '0;
  assign bus.mc_done      = rst & mc_done_int;
  assign bus.mc_busy      = rst & (state == BUSY);
  assign bus.valid        = valid_q;
  assign bus.retire       = rst & valid_q[STAGES-1];
  assign bus.stall_cycles = stat_q;

endmodule
